host_ctrl: RTL and testbench
============================

HOST_CTRL -- requirements
Module: host_ctrl

Interface
REQ-001 SHALL have parameter READ_LAT, default 1 (legal 1-3): cycles from the read_req_dmem strobe to valid data_out_dmem.
REQ-002 SHALL have clk  in  1  sole clock; all logic on rising edge.
REQ-003 SHALL have rst  in  1  synchronous, active-high reset.
REQ-004 SHALL have cmd_valid  in  1  command offered.
REQ-005 SHALL have cmd_ready  out  1  command accepted when cmd_valid and cmd_ready are both high.
REQ-006 SHALL have cmd_op  in  2  opcode: 00 WR_IMEM, 01 WR_DMEM, 10 RD_DMEM, 11 RUN.
REQ-007 SHALL have cmd_addr  in  9  target address.
REQ-008 SHALL have cmd_data  in  32  write data, or run cycle count for RUN.
REQ-009 SHALL have rsp_valid / rsp_ready / rsp_data  out / in / out(32)  read response handshake.
REQ-010 SHALL have write_to_imem, addr_imem_host[9], data_imem_host[32]  out  instruction-memory load port of the pipeline.
REQ-011 SHALL have write_to_dmem, addr_dmem_host[8], data_dmem_host[32], read_req_dmem  out  data-memory host port.
REQ-012 SHALL have data_out_dmem  in  32  data-memory read data from the pipeline.
REQ-013 SHALL have cpu_rst  out  1  pipeline reset, high = pipeline held.
REQ-014 SHALL have busy  out  1  high whenever the state is not IDLE.
REQ-015 SHALL have run_done  out  1  one-cycle pulse at the end of RUN.

Function
REQ-016 SHALL implement states IDLE, WRITE, RD_REQ, RD_WAIT, RESP, RUN; cmd_ready = 1 only in IDLE.
REQ-017 SHALL, when WR_IMEM or WR_DMEM is accepted, enter WRITE and drive the matching write strobe high for exactly that one cycle, with address/data taken from the command; it SHALL return to IDLE next.
REQ-018 SHALL drive addr_dmem_host from cmd_addr[7:0].
REQ-019 SHALL, when RD_DMEM is accepted, enter RD_REQ and assert read_req_dmem for one cycle, then wait READ_LAT cycles in RD_WAIT, then capture data_out_dmem into rsp_data.
REQ-020 SHALL hold rsp_valid high in RESP with rsp_data stable until rsp_ready is sampled high; it SHALL then return to IDLE on the next cycle.
REQ-021 SHALL, when RUN is accepted with N = cmd_data, hold cpu_rst low for exactly N consecutive cycles starting the cycle after acceptance, then raise cpu_rst and pulse run_done on the cycle cpu_rst returns high.
REQ-022 SHALL treat RUN with N = 0 as no cpu_rst deassertion, with run_done pulsing on the cycle after acceptance.
REQ-023 SHALL hold cpu_rst high in every state except RUN; the RUN counter SHALL be 32-bit down-count without wrap.
REQ-024 SHALL keep all memory strobes low outside WRITE/RD_REQ; address/data outputs SHALL hold their last values.
REQ-025 SHALL register all outputs; no input-to-output combinational path except none.
REQ-026 SHALL ignore cmd_* while not in IDLE; commands are never dropped, only stalled.

Reset
REQ-027 SHALL, on rst in any state, go to IDLE with cmd_ready=1, cpu_rst=1, all strobes 0, rsp_valid=0, run_done=0, busy=0, addresses/data/rsp_data=0.
REQ-028 SHALL abort RUN or a pending response on rst mid-operation, with no run_done pulse.

Configuration
REQ-029 SHALL, with HOST_CTRL_ADDR_CHK_EN defined, reject WR_DMEM/RD_DMEM with cmd_addr[8]=1: no strobe, sticky output addr_err set (cleared only by rst), and RD_DMEM responds with rsp_data=32'hDEADBEEF.
REQ-030 SHALL, without HOST_CTRL_ADDR_CHK_EN, have no addr_err port and silently truncate cmd_addr to 8 bits for dmem ops.

Verification
REQ-031 SHALL check: WR_IMEM addr 0x105 data 0x12345678 -> write_to_imem high one cycle with addr_imem_host=0x105, data_imem_host=0x12345678; cmd_ready low that cycle.
REQ-032 SHALL check: WR_DMEM addr 0x10 data 0xCAFEF00D, then RD_DMEM 0x10 with READ_LAT=1 -> read_req_dmem high one cycle, rsp_data=0xCAFEF00D held while rsp_ready=0 for 5 cycles.
REQ-033 SHALL check: RUN N=20 -> cpu_rst low exactly 20 cycles, run_done single pulse on the 21st cycle after acceptance; RUN N=0 -> cpu_rst never low, run_done next cycle.
REQ-034 SHALL check: rst asserted at cycle 10 of RUN N=100 -> cpu_rst=1, IDLE, no run_done, next cycle cmd_ready=1.
REQ-035 SHALL check: with HOST_CTRL_ADDR_CHK_EN, RD_DMEM addr 0x1FF -> no read_req_dmem, rsp_data=0xDEADBEEF, addr_err=1 until rst.

Source files
------------

// File: rtl/host_ctrl.sv
// host_ctrl: host-side command sequencer for a small pipeline.
// Accepts commands over a valid/ready handshake and turns them into
// instruction-memory writes, data-memory writes/reads, or a timed RUN window
// during which the pipeline reset (cpu_rst) is released for N cycles.
//
// Ports:
//   clk, rst              clock, synchronous active-high reset
//   cmd_valid/cmd_ready   command handshake (ready only in IDLE)
//   cmd_op/addr/data      opcode (00 WR_IMEM, 01 WR_DMEM, 10 RD_DMEM, 11 RUN)
//   rsp_valid/ready/data  read response handshake
//   write_to_imem, addr_imem_host, data_imem_host      imem load port
//   write_to_dmem, addr_dmem_host, data_dmem_host,
//   read_req_dmem, data_out_dmem                       dmem host port
//   cpu_rst               pipeline held in reset when high
//   busy                  state is not IDLE
//   run_done              one-cycle pulse when a RUN finishes
//   addr_err              (HOST_CTRL_ADDR_CHK_EN only) sticky bad-dmem-address flag
//
// Optional feature macro: HOST_CTRL_ADDR_CHK_EN -- reject dmem ops with
// cmd_addr[8]=1. Without it, dmem addresses are silently truncated to 8 bits.
//
// state     | meaning
// ----------+--------------------------------------------------
// S_IDLE    | waiting for a command, cmd_ready high
// S_WRITE   | one-cycle imem/dmem write strobe
// S_RD_REQ  | one-cycle read_req_dmem strobe
// S_RD_WAIT | waiting READ_LAT cycles for data_out_dmem
// S_RESP    | rsp_valid held until rsp_ready
// S_RUN     | cpu_rst low, counting down the run length

module host_ctrl #(
  parameter int READ_LAT = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [1:0]  cmd_op,
  input  logic [8:0]  cmd_addr,
  input  logic [31:0] cmd_data,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_data,
  output logic        write_to_imem,
  output logic [8:0]  addr_imem_host,
  output logic [31:0] data_imem_host,
  output logic        write_to_dmem,
  output logic [7:0]  addr_dmem_host,
  output logic [31:0] data_dmem_host,
  output logic        read_req_dmem,
  input  logic [31:0] data_out_dmem,
  output logic        cpu_rst,
  output logic        busy,
  output logic        run_done
`ifdef HOST_CTRL_ADDR_CHK_EN
  ,
  output logic        addr_err
`endif
);

  typedef enum logic [2:0] {
    S_IDLE, S_WRITE, S_RD_REQ, S_RD_WAIT, S_RESP, S_RUN
  } state_t;

  localparam logic [1:0]  OP_WR_IMEM = 2'b00;
  localparam logic [1:0]  OP_WR_DMEM = 2'b01;
  localparam logic [1:0]  OP_RD_DMEM = 2'b10;
  localparam logic [1:0]  OP_RUN     = 2'b11;
  localparam logic [31:0] BAD_DATA   = 32'hDEADBEEF;

  state_t      state, state_nxt;
  logic [31:0] run_cnt, run_cnt_nxt;
  logic [1:0]  lat_cnt, lat_cnt_nxt;
  logic        err_q, err_nxt;
  logic        bad_addr;

  logic        wr_imem_nxt, wr_dmem_nxt, rd_req_nxt, run_done_nxt, rsp_valid_nxt;
  logic [8:0]  addr_imem_nxt;
  logic [31:0] data_imem_nxt, data_dmem_nxt, rsp_data_nxt;
  logic [7:0]  addr_dmem_nxt;

`ifdef HOST_CTRL_ADDR_CHK_EN
  assign bad_addr = cmd_addr[8];
  assign addr_err = err_q;
`else
  assign bad_addr = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= S_IDLE;
      run_cnt <= '0;
      lat_cnt <= '0;
      err_q   <= 1'b0;
    end else begin
      state   <= state_nxt;
      run_cnt <= run_cnt_nxt;
      lat_cnt <= lat_cnt_nxt;
      err_q   <= err_nxt;
    end
  end

  always_comb begin
    state_nxt     = state;
    run_cnt_nxt   = run_cnt;
    lat_cnt_nxt   = lat_cnt;
    err_nxt       = err_q;
    wr_imem_nxt   = 1'b0;
    wr_dmem_nxt   = 1'b0;
    rd_req_nxt    = 1'b0;
    run_done_nxt  = 1'b0;
    rsp_valid_nxt = rsp_valid;
    rsp_data_nxt  = rsp_data;
    addr_imem_nxt = addr_imem_host;
    data_imem_nxt = data_imem_host;
    addr_dmem_nxt = addr_dmem_host;
    data_dmem_nxt = data_dmem_host;

    case (state)
      S_IDLE: begin
        if (cmd_valid) begin
          case (cmd_op)
            OP_WR_IMEM: begin
              state_nxt     = S_WRITE;
              wr_imem_nxt   = 1'b1;
              addr_imem_nxt = cmd_addr;
              data_imem_nxt = cmd_data;
            end
            OP_WR_DMEM: begin
              state_nxt = S_WRITE;
              if (bad_addr) begin
                err_nxt = 1'b1;
              end else begin
                wr_dmem_nxt   = 1'b1;
                addr_dmem_nxt = cmd_addr[7:0];
                data_dmem_nxt = cmd_data;
              end
            end
            OP_RD_DMEM: begin
              if (bad_addr) begin
                // Rejected read skips the memory and answers with a marker.
                err_nxt       = 1'b1;
                rsp_data_nxt  = BAD_DATA;
                rsp_valid_nxt = 1'b1;
                state_nxt     = S_RESP;
              end else begin
                state_nxt     = S_RD_REQ;
                rd_req_nxt    = 1'b1;
                addr_dmem_nxt = cmd_addr[7:0];
              end
            end
            default: begin
              // RUN of zero length never releases the pipeline.
              if (cmd_data == 32'd0) begin
                run_done_nxt = 1'b1;
              end else begin
                state_nxt   = S_RUN;
                run_cnt_nxt = cmd_data;
              end
            end
          endcase
        end
      end
      S_WRITE: state_nxt = S_IDLE;
      S_RD_REQ: begin
        state_nxt   = S_RD_WAIT;
        lat_cnt_nxt = 2'(READ_LAT - 1);
      end
      S_RD_WAIT: begin
        if (lat_cnt == 2'd0) begin
          rsp_data_nxt  = data_out_dmem;
          rsp_valid_nxt = 1'b1;
          state_nxt     = S_RESP;
        end else begin
          lat_cnt_nxt = lat_cnt - 2'd1;
        end
      end
      S_RESP: begin
        if (rsp_ready) begin
          rsp_valid_nxt = 1'b0;
          state_nxt     = S_IDLE;
        end
      end
      S_RUN: begin
        // Terminal count at 1: the cycle that loads N already counts as
        // the first low cycle, so the counter never reaches zero or wraps.
        if (run_cnt == 32'd1) begin
          run_done_nxt = 1'b1;
          state_nxt    = S_IDLE;
        end else begin
          run_cnt_nxt = run_cnt - 32'd1;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  // Outputs are registered from the next-state values so each one lines up
  // with the state it describes.
  always_ff @(posedge clk) begin
    if (rst) begin
      cmd_ready      <= 1'b1;
      rsp_valid      <= 1'b0;
      rsp_data       <= '0;
      write_to_imem  <= 1'b0;
      addr_imem_host <= '0;
      data_imem_host <= '0;
      write_to_dmem  <= 1'b0;
      addr_dmem_host <= '0;
      data_dmem_host <= '0;
      read_req_dmem  <= 1'b0;
      cpu_rst        <= 1'b1;
      busy           <= 1'b0;
      run_done       <= 1'b0;
    end else begin
      cmd_ready      <= (state_nxt == S_IDLE);
      rsp_valid      <= rsp_valid_nxt;
      rsp_data       <= rsp_data_nxt;
      write_to_imem  <= wr_imem_nxt;
      addr_imem_host <= addr_imem_nxt;
      data_imem_host <= data_imem_nxt;
      write_to_dmem  <= wr_dmem_nxt;
      addr_dmem_host <= addr_dmem_nxt;
      data_dmem_host <= data_dmem_nxt;
      read_req_dmem  <= rd_req_nxt;
      cpu_rst        <= (state_nxt != S_RUN);
      busy           <= (state_nxt != S_IDLE);
      run_done       <= run_done_nxt;
    end
  end

endmodule

// File: tb/tb_host_ctrl.sv
module tb_host_ctrl;
  localparam int READ_LAT = 1;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [1:0]  cmd_op = 2'b00;
  logic [8:0]  cmd_addr = '0;
  logic [31:0] cmd_data = '0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b0;
  logic [31:0] rsp_data;
  logic        write_to_imem;
  logic [8:0]  addr_imem_host;
  logic [31:0] data_imem_host;
  logic        write_to_dmem;
  logic [7:0]  addr_dmem_host;
  logic [31:0] data_dmem_host;
  logic        read_req_dmem;
  logic [31:0] data_out_dmem;
  logic        cpu_rst;
  logic        busy;
  logic        run_done;
`ifdef HOST_CTRL_ADDR_CHK_EN
  logic        addr_err;
`endif

  host_ctrl #(.READ_LAT(READ_LAT)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_addr(cmd_addr), .cmd_data(cmd_data),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
    .write_to_imem(write_to_imem), .addr_imem_host(addr_imem_host),
    .data_imem_host(data_imem_host),
    .write_to_dmem(write_to_dmem), .addr_dmem_host(addr_dmem_host),
    .data_dmem_host(data_dmem_host), .read_req_dmem(read_req_dmem),
    .data_out_dmem(data_out_dmem),
    .cpu_rst(cpu_rst), .busy(busy), .run_done(run_done)
`ifdef HOST_CTRL_ADDR_CHK_EN
    , .addr_err(addr_err)
`endif
  );

  always #5 clk = ~clk;

  // Data-memory model: data valid exactly READ_LAT cycles after the strobe,
  // garbage otherwise so a mistimed capture shows up.
  logic [31:0] mem [256];
  logic [31:0] rd_pipe_d [READ_LAT];
  logic        rd_pipe_v [READ_LAT];
  initial begin
    for (int i = 0; i < 256; i++) mem[i] = '0;
    for (int i = 0; i < READ_LAT; i++) begin rd_pipe_v[i] = 1'b0; rd_pipe_d[i] = '0; end
  end
  always @(posedge clk) begin
    if (write_to_dmem) mem[addr_dmem_host] <= data_dmem_host;
    rd_pipe_v[0] <= read_req_dmem;
    rd_pipe_d[0] <= mem[addr_dmem_host];
    for (int i = 1; i < READ_LAT; i++) begin
      rd_pipe_v[i] <= rd_pipe_v[i-1];
      rd_pipe_d[i] <= rd_pipe_d[i-1];
    end
  end
  assign data_out_dmem = rd_pipe_v[READ_LAT-1] ? rd_pipe_d[READ_LAT-1] : 32'h0BAD0BAD;

  int n_chk = 0;
  int n_pass = 0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, got, exp);
  endtask

  task automatic do_reset();
    @(negedge clk); rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst cmd_ready", 32'(cmd_ready), 32'd1);
    chk("rst cpu_rst", 32'(cpu_rst), 32'd1);
    chk("rst busy", 32'(busy), 32'd0);
    chk("rst strobes", 32'({write_to_imem, write_to_dmem, read_req_dmem}), 32'd0);
    chk("rst rsp_valid/run_done", 32'({rsp_valid, run_done}), 32'd0);
    chk("rst rsp_data", rsp_data, 32'd0);
    chk("rst addrs", 32'({addr_imem_host, addr_dmem_host}), 32'd0);
    chk("rst datas", data_imem_host | data_dmem_host, 32'd0);
    @(negedge clk); rst = 1'b0;
  endtask

  // Returns #1 after the accepting edge.
  task automatic send(input logic [1:0] op, input logic [8:0] addr, input logic [31:0] data);
    int k = 0;
    @(negedge clk);
    while (!cmd_ready && k < 300) begin @(negedge clk); k++; end
    if (!cmd_ready) chk("cmd_ready timeout", 32'(cmd_ready), 32'd1);
    cmd_valid = 1'b1; cmd_op = op; cmd_addr = addr; cmd_data = data;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
  endtask

  task automatic wait_rsp(output int lat, output int nreq);
    lat = 0;
    nreq = read_req_dmem ? 1 : 0;
    while (!rsp_valid && lat < 20) begin
      @(posedge clk); #1;
      lat++;
      if (read_req_dmem) nreq++;
    end
    if (!rsp_valid) chk("rsp_valid timeout", 32'(rsp_valid), 32'd1);
  endtask

  task automatic finish_rsp();
    @(negedge clk); rsp_ready = 1'b1;
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    chk("rsp_valid drop", 32'(rsp_valid), 32'd0);
    chk("idle after rsp", 32'({cmd_ready, busy}), 32'b10);
  endtask

  // Monitors a RUN from #1 after acceptance (cycle index 1).
  task automatic run_watch(input int ncyc, output int low, output int first_low,
                           output int last_low, output int ndone, output int done_at);
    low = 0; first_low = 0; last_low = 0; ndone = 0; done_at = 0;
    for (int i = 1; i <= ncyc; i++) begin
      if (!cpu_rst) begin
        low++;
        if (first_low == 0) first_low = i;
        last_low = i;
      end
      if (run_done) begin ndone++; done_at = i; end
      @(posedge clk); #1;
    end
  endtask

  typedef struct {
    logic [1:0]  op;
    logic [8:0]  addr;
    logic [31:0] data;
    logic [31:0] exp;
  } vec_t;
  vec_t vecs[$];

  initial begin
    int lat, nreq, low, fl, ll, nd, da;
    vecs.push_back('{2'b01, 9'h010, 32'hCAFEF00D, 32'h0});
    vecs.push_back('{2'b01, 9'h022, 32'h11112222, 32'h0});
    vecs.push_back('{2'b01, 9'h0FF, 32'hFFFFFFFF, 32'h0});
    vecs.push_back('{2'b01, 9'h000, 32'h00000001, 32'h0});
    vecs.push_back('{2'b10, 9'h022, 32'h0, 32'h11112222});
    vecs.push_back('{2'b10, 9'h0FF, 32'h0, 32'hFFFFFFFF});
    vecs.push_back('{2'b10, 9'h000, 32'h0, 32'h00000001});
`ifndef HOST_CTRL_ADDR_CHK_EN
    // Bit 8 is dropped for dmem ops.
    vecs.push_back('{2'b01, 9'h1A3, 32'hA5A5A5A5, 32'h0});
    vecs.push_back('{2'b10, 9'h0A3, 32'h0, 32'hA5A5A5A5});
    vecs.push_back('{2'b10, 9'h1A3, 32'h0, 32'hA5A5A5A5});
`endif

    do_reset();

    // WR_IMEM
    send(2'b00, 9'h105, 32'h12345678);
    chk("imem strobe", 32'(write_to_imem), 32'd1);
    chk("imem addr", 32'(addr_imem_host), 32'h105);
    chk("imem data", data_imem_host, 32'h12345678);
    chk("imem cmd_ready low", 32'(cmd_ready), 32'd0);
    chk("imem no dmem strobe", 32'(write_to_dmem), 32'd0);
    @(posedge clk); #1;
    chk("imem strobe one cycle", 32'(write_to_imem), 32'd0);
    chk("imem addr held", 32'(addr_imem_host), 32'h105);
    chk("imem back idle", 32'(cmd_ready), 32'd1);

    // Table of dmem writes/reads
    foreach (vecs[i]) begin
      send(vecs[i].op, vecs[i].addr, vecs[i].data);
      if (vecs[i].op == 2'b01) begin
        chk($sformatf("v%0d wr strobe", i), 32'(write_to_dmem), 32'd1);
        chk($sformatf("v%0d wr addr", i), 32'(addr_dmem_host), 32'(vecs[i].addr[7:0]));
        chk($sformatf("v%0d wr data", i), data_dmem_host, vecs[i].data);
        @(posedge clk); #1;
        chk($sformatf("v%0d wr strobe off", i), 32'(write_to_dmem), 32'd0);
      end else begin
        chk($sformatf("v%0d rd addr", i), 32'(addr_dmem_host), 32'(vecs[i].addr[7:0]));
        wait_rsp(lat, nreq);
        chk($sformatf("v%0d rd latency", i), 32'(lat), 32'(1 + READ_LAT));
        chk($sformatf("v%0d rd_req count", i), 32'(nreq), 32'd1);
        chk($sformatf("v%0d rsp_data", i), rsp_data, vecs[i].exp);
        finish_rsp();
      end
    end

    // Response held while rsp_ready stays low
    send(2'b10, 9'h010, 32'h0);
    wait_rsp(lat, nreq);
    chk("hold rd_req count", 32'(nreq), 32'd1);
    for (int c = 0; c < 5; c++) begin
      @(posedge clk); #1;
      chk($sformatf("hold c%0d", c), 32'(rsp_valid), 32'd1);
      chk($sformatf("hold data c%0d", c), rsp_data, 32'hCAFEF00D);
      chk($sformatf("hold busy c%0d", c), 32'({busy, cmd_ready}), 32'b10);
    end
    finish_rsp();

    // RUN N=20
    send(2'b11, 9'h0, 32'd20);
    chk("run busy", 32'({busy, cmd_ready}), 32'b10);
    run_watch(30, low, fl, ll, nd, da);
    chk("run20 low cycles", 32'(low), 32'd20);
    chk("run20 low span", 32'(ll - fl + 1), 32'd20);
    chk("run20 first low", 32'(fl), 32'd1);
    chk("run20 done count", 32'(nd), 32'd1);
    chk("run20 done at", 32'(da), 32'd21);

    // RUN N=0
    send(2'b11, 9'h0, 32'd0);
    run_watch(5, low, fl, ll, nd, da);
    chk("run0 low cycles", 32'(low), 32'd0);
    chk("run0 done count", 32'(nd), 32'd1);
    chk("run0 done at", 32'(da), 32'd1);

    // RUN N=1
    send(2'b11, 9'h0, 32'd1);
    run_watch(5, low, fl, ll, nd, da);
    chk("run1 low cycles", 32'(low), 32'd1);
    chk("run1 done at", 32'(da), 32'd2);

    // Reset at cycle 10 of RUN N=100
    send(2'b11, 9'h0, 32'd100);
    for (int i = 1; i < 10; i++) begin @(posedge clk); #1; end
    chk("run100 low mid", 32'(cpu_rst), 32'd0);
    @(negedge clk); rst = 1'b1;
    @(posedge clk); #1;
    chk("abort cpu_rst", 32'(cpu_rst), 32'd1);
    chk("abort idle", 32'({busy, cmd_ready}), 32'b01);
    chk("abort run_done", 32'(run_done), 32'd0);
    @(negedge clk); rst = 1'b0;
    run_watch(110, low, fl, ll, nd, da);
    chk("abort no low after", 32'(low), 32'd0);
    chk("abort no run_done", 32'(nd), 32'd0);
    chk("abort cmd_ready", 32'(cmd_ready), 32'd1);

    // Reset with a pending response
    send(2'b10, 9'h022, 32'h0);
    wait_rsp(lat, nreq);
    chk("pend rsp_data", rsp_data, 32'h11112222);
    @(negedge clk); rst = 1'b1;
    @(posedge clk); #1;
    chk("pend abort rsp_valid", 32'(rsp_valid), 32'd0);
    chk("pend abort rsp_data", rsp_data, 32'd0);
    @(negedge clk); rst = 1'b0;

`ifdef HOST_CTRL_ADDR_CHK_EN
    chk("addr_err clear", 32'(addr_err), 32'd0);
    send(2'b10, 9'h1FF, 32'h0);
    wait_rsp(lat, nreq);
    chk("bad rd no rd_req", 32'(nreq), 32'd0);
    chk("bad rd data", rsp_data, 32'hDEADBEEF);
    chk("bad rd addr_err", 32'(addr_err), 32'd1);
    finish_rsp();
    send(2'b01, 9'h130, 32'h55AA55AA);
    chk("bad wr no strobe", 32'(write_to_dmem), 32'd0);
    send(2'b01, 9'h030, 32'h55AA55AA);
    chk("good wr strobe", 32'(write_to_dmem), 32'd1);
    chk("addr_err sticky", 32'(addr_err), 32'd1);
    do_reset();
    chk("addr_err rst", 32'(addr_err), 32'd0);
`endif

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
